// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector.
// Build option SEQ_DET_OVERLAP_EN (consumed by serial_seq_detector) selects overlapping detection.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HUNT = 1'b1
  } seq_state_e;

  localparam int             DEF_PAT_W   = 4;
  localparam logic [3:0]     DEF_PATTERN = 4'b1011;
  localparam int             DEF_CNT_W   = 8;

  // Largest value a w-bit saturating counter may hold; w is expected to stay below 31.
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DEF_CNT_MAX = sat_max(DEF_CNT_W);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at its maximum instead of wrapping.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/serial_seq_detector.sv
// Serial pattern detector: shifts in qualified bits, pulses match and counts matches.
// Build option SEQ_DET_OVERLAP_EN: keep history after a match so a suffix can start the next one.
//
// state | meaning
// IDLE  | detector disabled, history and fill held at zero
// HUNT  | enabled, shifting in bits while din_valid is high
module serial_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  seq_state_e        state;
  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;
  logic              hit_q;

  logic              accept;
  logic [PAT_W-1:0]  hist_nx;
  logic [FILL_W-1:0] fill_nx;
  logic              hit;

  assign accept  = (state == HUNT) && din_valid;
  assign hist_nx = {history[PAT_W-2:0], din};
  assign fill_nx = (fill == FULL) ? FULL : fill + FILL_W'(1);
  // fill guards against the zeroed history matching an all-zero-prefixed pattern early
  assign hit     = accept && (fill_nx == FULL) && (hist_nx == PATTERN);

  // hit_q marks the bit that completed the pattern; match follows one edge later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      history <= '0;
      fill    <= '0;
      hit_q   <= 1'b0;
      match   <= 1'b0;
    end else begin
      state <= en ? HUNT : IDLE;
      busy  <= en;
      match <= clr ? 1'b0 : hit_q;
      if (clr) begin
        history <= '0;
        fill    <= '0;
        hit_q   <= 1'b0;
      end else begin
        hit_q <= hit;
        if ((state == HUNT) && !en) begin
          history <= '0;
          fill    <= '0;
        end else if (hit) begin
`ifdef SEQ_DET_OVERLAP_EN
          history <= hist_nx;
          fill    <= fill_nx;
`else
          history <= '0;
          fill    <= '0;
`endif
        end else if (accept) begin
          history <= hist_nx;
          fill    <= fill_nx;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_q),
    .clr (clr),
    .cnt (match_cnt)
  );

endmodule
